// File: rtl/panda_muldiv.sv
// -----------------------------------------------------------------------------
// panda_muldiv
// Iterative RV32M multiply/divide unit for the Panda execute stage.
// One radix-2 step per cycle: shift-add multiply on operand magnitudes, and
// restoring division on operand magnitudes. Sign fix-up happens in a single
// FIX cycle. Divide-by-zero and signed overflow bypass the iteration and
// complete on the accepting edge.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      request valid
//   ready_o      unit can accept a request (IDLE or DONE)
//   operator_i   funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   operand_a_i  rs1 / multiplicand / dividend
//   operand_b_i  rs2 / multiplier / divisor
//   flush_i      abort in-flight operation (overrides a same-cycle accept)
//   valid_o      one-cycle completion pulse
//   result_o     result, held until the next completion
// -----------------------------------------------------------------------------
module panda_muldiv #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       operator_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;

  // Operation context captured on accept
  logic [2:0]          op_q;
  logic                neg_q;       // result must be negated in FIX
  logic [Width-1:0]    opnd_q;      // multiplicand magnitude / divisor magnitude
  logic [2*Width-1:0]  acc_q;       // {hi,lo} product or {remainder,quotient}

  // Request decode
  logic                is_div;
  logic                a_signed, b_signed;
  logic                a_neg, b_neg;
  logic [Width-1:0]    a_mag, b_mag;
  logic                res_neg;
  logic                div_zero, div_ovf, fast;
  logic [Width-1:0]    fast_res;
  logic                accept;

  // Iteration step
  logic [Width:0]      mul_sum;
  logic [2*Width-1:0]  mul_next;
  logic [Width:0]      rem_sh;
  logic [Width:0]      diff;
  logic [2*Width-1:0]  div_next;

  // Fix-up
  logic [2*Width-1:0]  prod_fix;
  logic [Width-1:0]    div_val;
  logic [Width-1:0]    fix_res;

  function automatic logic [Width-1:0] negate_w(input logic [Width-1:0] v);
    return ~v + Width'(1);
  endfunction

  function automatic logic [2*Width-1:0] negate_2w(input logic [2*Width-1:0] v);
    return ~v + (2*Width)'(1);
  endfunction

  assign ready_o = (state_q == IDLE) || (state_q == DONE);
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    is_div   = operator_i[2];
    // DIV/REM are signed; among multiplies MULH signs both, MULHSU only a
    a_signed = is_div ? ~operator_i[0] : (operator_i[1:0] == 2'b01 || operator_i[1:0] == 2'b10);
    b_signed = is_div ? ~operator_i[0] : (operator_i[1:0] == 2'b01);
    a_neg    = a_signed && operand_a_i[Width-1];
    b_neg    = b_signed && operand_b_i[Width-1];
    a_mag    = a_neg ? negate_w(operand_a_i) : operand_a_i;
    b_mag    = b_neg ? negate_w(operand_b_i) : operand_b_i;
    // Remainder follows the dividend's sign; everything else the sign product
    res_neg  = (is_div && operator_i[1]) ? a_neg : (a_neg ^ b_neg);

    div_zero = is_div && (operand_b_i == '0);
    div_ovf  = is_div && !operator_i[0] &&
               (operand_a_i == {1'b1, {(Width-1){1'b0}}}) && (operand_b_i == '1);
    fast     = div_zero || div_ovf;

    if (div_zero) fast_res = operator_i[1] ? operand_a_i : '1;
    else          fast_res = operator_i[1] ? '0 : operand_a_i;
  end

  always_comb begin
    // Multiply: conditionally add multiplicand into the high half, shift right
    mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[Width-1:1]};

    // Restoring divide: remainder is one bit wider so a large divisor cannot
    // overflow the shifted partial remainder; diff[Width] is the borrow
    rem_sh   = acc_q[2*Width-1:Width-1];
    diff     = rem_sh - {1'b0, opnd_q};
    if (!diff[Width]) div_next = {diff[Width-1:0], acc_q[Width-2:0], 1'b1};
    else              div_next = {rem_sh[Width-1:0], acc_q[Width-2:0], 1'b0};

    prod_fix = neg_q ? negate_2w(acc_q) : acc_q;
    div_val  = op_q[1] ? acc_q[2*Width-1:Width] : acc_q[Width-1:0];
    if (op_q[2])                fix_res = neg_q ? negate_w(div_val) : div_val;
    else if (op_q[1:0] == 2'b00) fix_res = prod_fix[Width-1:0];
    else                        fix_res = prod_fix[2*Width-1:Width];
  end

  // Control FSM with registered completion outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (accept) begin
              if (fast) begin
                state_q  <= DONE;
                result_o <= fast_res;
                valid_o  <= 1'b1;
              end else begin
                state_q <= CALC;
                cnt_q   <= CntW'(Width);
              end
            end else begin
              state_q <= IDLE;
            end
          end
          CALC: begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_q <= FIX;
          end
          FIX: begin
            state_q  <= DONE;
            result_o <= fix_res;
            valid_o  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Datapath: operands captured on accept, one step per CALC cycle
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= operator_i;
      neg_q <= res_neg;
      if (is_div) begin
        opnd_q <= b_mag;
        acc_q  <= {{Width{1'b0}}, a_mag};
      end else begin
        opnd_q <= a_mag;
        acc_q  <= {{Width{1'b0}}, b_mag};
      end
    end else if (state_q == CALC) begin
      acc_q <= op_q[2] ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_panda_muldiv.sv
module tb_panda_muldiv;

  localparam int W = 32;

  logic          clk;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [2:0]    operator_i;
  logic [W-1:0]  operand_a_i;
  logic [W-1:0]  operand_b_i;
  logic          flush_i;
  logic          valid_o;
  logic [W-1:0]  result_o;

  int checks = 0;
  int errors = 0;

  panda_muldiv #(.Width(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (caller is #1 after an edge with ready_o high), then
  // wait for completion and check latency, result and ready behaviour.
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    logic rdy_low;
    valid_i     = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    tick();
    valid_i = 1'b0;
    n = 0;
    rdy_low = 1'b1;
    while (!valid_o && n < 40) begin
      if (ready_o) rdy_low = 1'b0;
      tick();
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_result"}, result_o, exp);
    check({name, "_ready_done"}, {31'd0, ready_o}, 32'd1);
    if (lat > 0) check({name, "_ready_busy"}, {31'd0, rdy_low}, 32'd1);
  endtask

  initial begin
    int   watch;
    logic saw_v;

    vecs[0]  = '{3'd0, 32'd30,         32'd3,         32'd90,         33};
    vecs[1]  = '{3'd1, 32'hFFFFFFC2,   32'd5,         32'hFFFFFFFF,   33};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,  32'hFFFFFFFE,   33};
    vecs[3]  = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,  32'h00000001,   33};
    vecs[4]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,  32'h00000000,   33};
    vecs[5]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,  32'hFFFFFFFF,   33};
    vecs[6]  = '{3'd4, 32'hFFFFFFC2,   32'd5,         32'hFFFFFFF4,   33};
    vecs[7]  = '{3'd6, 32'hFFFFFFC2,   32'd5,         32'hFFFFFFFE,   33};
    vecs[8]  = '{3'd4, 32'hFFFFFF7A,   32'hFFFFFFA6,  32'd1,          33};
    vecs[9]  = '{3'd6, 32'hFFFFFF7A,   32'hFFFFFFA6,  32'hFFFFFFD4,   33};
    vecs[10] = '{3'd5, 32'd30,         32'd50,        32'd0,          33};
    vecs[11] = '{3'd7, 32'd30,         32'd50,        32'd30,         33};
    vecs[12] = '{3'd4, 32'd30,         32'd0,         32'hFFFFFFFF,   0};
    vecs[13] = '{3'd7, 32'd30,         32'd0,         32'd30,         0};
    vecs[14] = '{3'd4, 32'h80000000,   32'hFFFFFFFF,  32'h80000000,   0};
    vecs[15] = '{3'd6, 32'h80000000,   32'hFFFFFFFF,  32'd0,          0};
    vecs[16] = '{3'd5, 32'hFFFFFFFF,   32'h80000000,  32'd1,          33};
    vecs[17] = '{3'd7, 32'hFFFFFFFF,   32'h80000000,  32'h7FFFFFFF,   33};
    vecs[18] = '{3'd3, 32'h80000000,   32'd2,         32'd1,          33};

    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    flush_i     = 1'b0;
    operator_i  = 3'd0;
    operand_a_i = '0;
    operand_b_i = '0;
    #12;
    check("reset_ready",  {31'd0, ready_o}, 32'd1);
    check("reset_valid",  {31'd0, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      tick();
      check($sformatf("vec%0d_pulse", i), {31'd0, valid_o}, 32'd0);
      check($sformatf("vec%0d_hold", i), result_o, vecs[i].exp);
    end

    // Flush 10 cycles into a DIV; a fast-path request during CALC must be ignored
    valid_i = 1'b1; operator_i = 3'd4; operand_a_i = 32'd1000; operand_b_i = 32'd7;
    tick();
    saw_v = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i >= 3 && i <= 6) begin
        valid_i = 1'b1; operator_i = 3'd5; operand_a_i = 32'd100; operand_b_i = 32'd0;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (valid_o) saw_v = 1'b1;
    end
    valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_ready",  {31'd0, ready_o}, 32'd1);
    check("flush_valid",  {31'd0, valid_o}, 32'd0);
    check("flush_result", result_o, 32'd1);
    for (watch = 0; watch < 40; watch++) begin
      tick();
      if (valid_o) saw_v = 1'b1;
    end
    check("flush_no_valid", {31'd0, saw_v}, 32'd0);
    run("post_flush_mul", 3'd0, 32'd30, 32'd50, 32'd1500, 33);
    tick();

    // Flush overrides a same-cycle accept (fast-path op would complete at once)
    flush_i = 1'b1; valid_i = 1'b1; operator_i = 3'd4; operand_a_i = 32'd5; operand_b_i = 32'd0;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    saw_v = valid_o;
    tick();
    if (valid_o) saw_v = 1'b1;
    check("flush_accept_valid",  {31'd0, saw_v}, 32'd0);
    check("flush_accept_result", result_o, 32'd1500);

    // Back-to-back: accepts issued in the DONE cycle
    run("b2b_first",  3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, 33);
    run("b2b_second", 3'd3, 32'h80000000, 32'd4, 32'd2, 33);
    run("b2b_fast",   3'd4, 32'd5,        32'd0, 32'hFFFFFFFF, 0);
    tick();
    check("b2b_pulse_end", {31'd0, valid_o}, 32'd0);

    // Reset asserted mid-CALC
    valid_i = 1'b1; operator_i = 3'd0; operand_a_i = 32'd30; operand_b_i = 32'd3;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    check("midcalc_busy", {31'd0, ready_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("midrst_ready",  {31'd0, ready_o}, 32'd1);
    check("midrst_valid",  {31'd0, valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    saw_v = 1'b0;
    for (watch = 0; watch < 40; watch++) begin
      tick();
      if (valid_o) saw_v = 1'b1;
    end
    check("midrst_no_valid", {31'd0, saw_v}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
